writeback_regfile: RTL

Write-back stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB buffer outputs (RegWrite, MemtoReg, RegDstAddress, MemReadData, ALUResult), selects the write-back value and commits it to a 32 x `WORD register file. Serves the two decode-stage read ports with same-cycle write-through bypass, and exports the WB write to the forwarding unit. Keeps a commit counter and a last-commit record for debug and test.

---
 rtl/writeback_regfile.sv | 107 ++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// writeback_regfile
// Write-back stage and architectural register file for the 5-stage MIPS
// pipeline. It picks the write-back value from the MEM/WB buffer and commits
// it to a 32-entry register file. It also serves the two decode-stage read
// ports, with a bypass so that a write in flight is visible in the same cycle.
// The current write is exported to the forwarding unit. A commit counter and
// a record of the last commit are kept for debug and test.

`ifndef WORD
`define WORD [31:0]
`endif

module writeback_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite_in,
    input  logic             MemtoReg_in,
    input  logic [4:0]       RegDstAddress_in,
    input  logic `WORD       MemReadData_in,
    input  logic `WORD       ALUResult_in,
    input  logic [4:0]       ReadAddr1,
    input  logic [4:0]       ReadAddr2,
    output logic `WORD       ReadData1,
    output logic `WORD       ReadData2,
    output logic             WB_RegWrite,
    output logic [4:0]       WB_Address,
    output logic `WORD       WB_Data,
    output logic [CNT_W-1:0] CommitCount,
    output logic [4:0]       LastAddr,
    output logic `WORD       LastData
);

    // Architectural state
    logic `WORD       r_regs [0:31];
    logic [CNT_W-1:0] r_commitCount;
    logic [4:0]       r_lastAddr;
    logic `WORD       r_lastData;

    // Write-back value and commit qualifier
    logic `WORD w_writeData;
    logic       w_commit;

    // Select the write-back value. A write is a real commit only when it is
    // enabled, does not target $0, and is not being squashed by reset in the
    // same cycle. Reset therefore also disables the bypass path.
    always_comb begin
        w_writeData = ALUResult_in;
        if (MemtoReg_in) begin
            w_writeData = MemReadData_in;
        end
        w_commit = RegWrite_in && (RegDstAddress_in != 5'd0) && !reset;
    end

    // Commit the write into the array, and update the counter and the
    // last-commit record on the same edge. Reset clears everything and wins
    // over a simultaneous write. The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_commitCount <= '0;
            r_lastAddr    <= '0;
            r_lastData    <= '0;
        end else if (w_commit) begin
            r_regs[RegDstAddress_in] <= w_writeData;
            r_commitCount            <= r_commitCount + CNT_W'(1);
            r_lastAddr               <= RegDstAddress_in;
            r_lastData               <= w_writeData;
        end
    end

    // Read port 1: $0 is hard-wired to zero. Otherwise a committing write to
    // the same register is bypassed, so decode sees it without waiting a cycle.
    always_comb begin
        ReadData1 = r_regs[ReadAddr1];
        if (ReadAddr1 == 5'd0) begin
            ReadData1 = '0;
        end else if (w_commit && (RegDstAddress_in == ReadAddr1)) begin
            ReadData1 = w_writeData;
        end
    end

    // Read port 2: same rules as port 1, evaluated independently
    always_comb begin
        ReadData2 = r_regs[ReadAddr2];
        if (ReadAddr2 == 5'd0) begin
            ReadData2 = '0;
        end else if (w_commit && (RegDstAddress_in == ReadAddr2)) begin
            ReadData2 = w_writeData;
        end
    end

    // Export the current write to the forwarding unit. It also drives the
    // debug view of the committed state.
    always_comb begin
        WB_RegWrite = w_commit;
        WB_Address  = RegDstAddress_in;
        WB_Data     = w_writeData;
        CommitCount = r_commitCount;
        LastAddr    = r_lastAddr;
        LastData    = r_lastData;
    end

endmodule
